// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Accepts one byte/half/word access at a time. Sub-word stores are done as
// read-modify-write, and load results are sign- or zero-extended. Misaligned
// accesses and illegal opcodes complete with an error and never touch memory.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rbar_w,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state_reg, state_next;

  logic [3:0]        op_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;

  // Address bits above the memory window wrap by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Request decode: opcode legality and alignment.
  logic [1:0] req_size;
  logic       req_legal;
  logic       req_misaligned;
  logic       req_err;
  logic       accept;

  assign req_size       = req_op[1:0];
  assign req_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                          (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_err        = !req_legal || req_misaligned;
  assign accept         = (state_reg == IDLE) && req_valid;

  // Flag the eight defined access types as legal.
  always_comb begin
    req_legal = 1'b0;
    case (req_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: req_legal = 1'b1;
      default:                   req_legal = 1'b0;
    endcase
  end

  // State register; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: errors go straight to RESP, SW skips the read.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_op[3] && req_size == 2'b10) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = op_reg[3] ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request on acceptance and the memory word while in RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        op_reg    <= req_op;
        addr_reg  <= req_addr[ADDR_W+1:0];
        wdata_reg <= req_wdata;
        err_reg   <= req_err;
      end
      if (state_reg == RD) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  // Store merge: each byte lane takes store data if addressed, else keeps
  // the word read back in RD. SW addresses every lane.
  logic [31:0] merged_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;
      assign lane_hit = (op_reg[1:0] == 2'b10) ? 1'b1 :
                        op_reg[0] ? (addr_reg[1] == 1'(gi / 2)) :
                                    (addr_reg[1:0] == 2'(gi));
      assign lane_src = (op_reg[1:0] == 2'b10) ? wdata_reg[8*gi +: 8] :
                        op_reg[0] ? wdata_reg[8*(gi % 2) +: 8] :
                                    wdata_reg[7:0];
      assign merged_word[8*gi +: 8] = lane_hit ? lane_src : rdata_reg[8*gi +: 8];
    end
  endgenerate

  // Load extraction from the captured word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_result;

  assign ld_byte = rdata_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign ld_half = rdata_reg[{addr_reg[1], 4'b0000} +: 16];

  // Extend the addressed lane according to the load type; stores yield 0.
  always_comb begin
    load_result = '0;
    case (op_reg)
      4'b0000: load_result = {{24{ld_byte[7]}}, ld_byte};
      4'b0001: load_result = {{16{ld_half[15]}}, ld_half};
      4'b0010: load_result = rdata_reg;
      4'b0100: load_result = {24'h0, ld_byte};
      4'b0101: load_result = {16'h0, ld_half};
      default: load_result = '0;
    endcase
  end

  // Outputs decoded from state; memory and response buses idle at zero.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_rbar_w = 1'b0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: req_ready = 1'b1;
      RD: begin
        mem_addr = {{(32-ADDR_W){1'b0}}, addr_reg[ADDR_W+1:2]};
      end
      WR: begin
        mem_addr   = {{(32-ADDR_W){1'b0}}, addr_reg[ADDR_W+1:2]};
        mem_rbar_w = 1'b1;
        mem_wdata  = merged_word;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        resp_rdata = err_reg ? 32'h0 : load_result;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-level reference memory predicts each
// response and write; a scoreboard queue holds the predictions until the
// unit responds.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rbar_w;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rbar_w (mem_rbar_w),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_rbar_w) mem[mem_addr[7:0]] <= mem_wdata;
  end

  // Reference memory, byte addressed, 1 KiB window.
  logic [7:0] ref_b [1024];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;
  int wr_count = 0;
  int quiet_bad = 0;
  logic [31:0] last_waddr, last_wdata;
  int last_wcyc;

  typedef struct {
    string       tag;
    int          acc;
    int          due;
    logic [31:0] rdata;
    logic [31:0] err;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          wsnap;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int w;
    w = a & ~3;
    return {ref_b[w+3], ref_b[w+2], ref_b[w+1], ref_b[w]};
  endfunction

  // Drive one request (at a falling edge), wait for acceptance, predict.
  // req_valid is left high so consecutive calls are back-to-back.
  task automatic send(input string tag, input logic [3:0] op,
                      input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   a;
    int   n;
    logic legal, mis;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_eq({tag, "_accept_timeout"}, {31'h0, req_ready}, 32'h1);
      return;
    end
    a = int'(addr[9:0]);
    legal = (op == 4'b0000 || op == 4'b0001 || op == 4'b0010 || op == 4'b0100 ||
             op == 4'b0101 || op == 4'b1000 || op == 4'b1001 || op == 4'b1010);
    mis = (op[1:0] == 2'b01 && addr[0]) || (op[1:0] == 2'b10 && addr[1:0] != 2'b00);
    e.tag = tag; e.acc = cyc; e.rdata = 0; e.err = 0; e.nwr = 0;
    e.waddr = 0; e.wdata = 0; e.wsnap = wr_count;
    if (!legal || mis) begin
      e.err = 1;
      e.due = cyc + 1;
    end else if (!op[3]) begin
      e.due = cyc + 2;
      case (op)
        4'b0000: e.rdata = {{24{ref_b[a][7]}}, ref_b[a]};
        4'b0100: e.rdata = {24'h0, ref_b[a]};
        4'b0001: e.rdata = {{16{ref_b[a+1][7]}}, ref_b[a+1], ref_b[a]};
        4'b0101: e.rdata = {16'h0, ref_b[a+1], ref_b[a]};
        default: e.rdata = ref_word(a);
      endcase
    end else begin
      e.nwr = 1;
      case (op[1:0])
        2'b00: ref_b[a] = wd[7:0];
        2'b01: begin ref_b[a] = wd[7:0]; ref_b[a+1] = wd[15:8]; end
        default: begin
          ref_b[a] = wd[7:0];    ref_b[a+1] = wd[15:8];
          ref_b[a+2] = wd[23:16]; ref_b[a+3] = wd[31:24];
        end
      endcase
      e.due   = (op[1:0] == 2'b10) ? cyc + 2 : cyc + 3;
      e.waddr = 32'(a >> 2);
      e.wdata = ref_word(a);
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: records writes, checks idle quietness and scoreboard responses.
  always @(negedge clk) begin
    exp_t e;
    if (mem_rbar_w) begin
      wr_count++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
      last_wcyc  = cyc;
    end
    if (req_ready && (mem_rbar_w || mem_addr != 0 || mem_wdata != 0)) quiet_bad++;
    if (!resp_valid && (resp_rdata != 0 || resp_err)) quiet_bad++;
    if (resp_valid && (mem_rbar_w || mem_addr != 0 || mem_wdata != 0)) quiet_bad++;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      $display("txn %-12s resp_valid=%0d rdata=0x%08h err=%0d (exp 0x%08h err=%0d)",
               e.tag, resp_valid, resp_rdata, resp_err, e.rdata, e.err);
      check_eq({e.tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
      check_eq({e.tag, "_rdata"}, resp_rdata, e.rdata);
      check_eq({e.tag, "_err"}, {31'h0, resp_err}, e.err);
      check_eq({e.tag, "_nwrites"}, 32'(wr_count - e.wsnap), 32'(e.nwr));
      if (e.nwr == 1 && wr_count != e.wsnap) begin
        check_eq({e.tag, "_waddr"}, last_waddr, e.waddr);
        check_eq({e.tag, "_wdata"}, last_wdata, e.wdata);
        check_eq({e.tag, "_wcycle"}, 32'(last_wcyc), 32'(e.due - 1));
      end
    end else if (resp_valid) begin
      check_eq("spurious_resp", {31'h0, resp_valid}, 32'h0);
    end
    if (sb.size() > 0 && sb[0].acc < cyc && req_ready) begin
      check_eq("ready_while_busy", {31'h0, req_ready}, 32'h0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [3:0] OP_LB = 4'b0000, OP_LH = 4'b0001, OP_LW = 4'b0010,
                         OP_LBU = 4'b0100, OP_LHU = 4'b0101,
                         OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;

  initial begin
    logic [3:0] op_tab [10];
    int snap;
    int bad;
    int n;
    op_tab = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 4'b0011, 4'b1100};

    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'(i);
      ref_b[4*i]   = 8'(i);
      ref_b[4*i+1] = 8'h0;
      ref_b[4*i+2] = 8'h0;
      ref_b[4*i+3] = 8'h0;
    end
    rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check_eq("rst_mem_rbar_w", {31'h0, mem_rbar_w}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed accesses.
    send("lw_14", OP_LW, 32'h14, 0);          req_valid = 1'b0; @(negedge clk);
    send("lb_3c0", OP_LB, 32'h3C0, 0);        req_valid = 1'b0; @(negedge clk);
    send("lbu_3c0", OP_LBU, 32'h3C0, 0);      req_valid = 1'b0; @(negedge clk);
    send("lhu_3c2", OP_LHU, 32'h3C2, 0);      req_valid = 1'b0; @(negedge clk);
    send("sb_0d", OP_SB, 32'h0D, 32'h123456AB); req_valid = 1'b0; @(negedge clk);
    send("lw_misal", OP_LW, 32'h06, 0);       req_valid = 1'b0; @(negedge clk);
    send("op_0011", 4'b0011, 32'h10, 0);      req_valid = 1'b0; repeat (3) @(negedge clk);

    // Reset while in RD abandons the SH; reset also overrides req_valid.
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h0A; req_wdata = 32'h0000BEEF;
    check_eq("abort_ready", {31'h0, req_ready}, 32'h1);
    snap = wr_count;
    @(negedge clk);
    check_eq("abort_rd_addr", mem_addr, 32'h2);
    check_eq("abort_rd_rbar_w", {31'h0, mem_rbar_w}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_after", {31'h0, req_ready}, 32'h1);
    check_eq("abort_rbar_w", {31'h0, mem_rbar_w}, 32'h0);
    check_eq("abort_mem_addr", mem_addr, 32'h0);
    check_eq("abort_mem_wdata", mem_wdata, 32'h0);
    check_eq("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    check_eq("rst_over_valid", {31'h0, req_ready}, 32'h1);
    check_eq("rst_over_rbar_w", {31'h0, mem_rbar_w}, 32'h0);
    rst = 1'b0; req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort_nwrites", 32'(wr_count - snap), 32'h0);
    check_eq("abort_word2", mem[2], 32'h2);
    send("lw_08", OP_LW, 32'h08, 0);          req_valid = 1'b0; @(negedge clk);

    // Back-to-back with req_valid held high.
    send("sw_400", OP_SW, 32'h400, 32'hDEADBEEF);
    send("lw_0", OP_LW, 32'h0, 0);
    send("sh_102", OP_SH, 32'h102, 32'h1234CAFE);
    send("lh_102", OP_LH, 32'h102, 0);
    send("lhu_102", OP_LHU, 32'h102, 0);
    send("lb_103", OP_LB, 32'h103, 0);
    send("lh_misal", OP_LH, 32'h101, 0);
    send("sw_misal", OP_SW, 32'h2, 32'hFFFFFFFF);
    send("op_0110", 4'b0110, 32'h4, 0);
    send("sb_wrap", OP_SB, 32'hFFFF_F001, 32'h77);
    send("lbu_001", OP_LBU, 32'h001, 0);
    send("lw_100", OP_LW, 32'h100, 0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Random mix over a small window, with high address bits set at random.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 63)) | ($urandom & 32'hFFFF_FC00);
      send($sformatf("rnd%0d", i), op_tab[$urandom_range(0, 9)], ra, $urandom);
      if ($urandom_range(0, 1) == 0) begin
        req_valid = 1'b0;
        @(negedge clk);
      end
    end
    req_valid = 1'b0;

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'h0);
    repeat (2) @(negedge clk);

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_word(4 * i)) bad++;
    end
    check_eq("mem_image", 32'(bad), 32'h0);
    check_eq("quiet_outputs", 32'(quiet_bad), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
